asrm_fetch_regs: RTL and testbench
==================================

# asrm_fetch_regs

Front/back end wrapped around the combinational ASRM ALU. It fetches 8-bit instructions over a simple request/ready memory handshake and holds the 16-entry register file, including the working, status and program-counter registers. It presents operands to the ALU and commits the ALU result (`out`/`out_reg`) back into the register file. Together with the ALU it forms a complete two-phase (fetch, execute) ASRM core.

## Interface
- `wordsize`, 16, register, program-counter and memory-address width.
- `pc_reset`, 0, program-counter value loaded on reset.

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  instruction fetch request.
- `mem_addr`  out  wordsize  fetch address; equals PC.
- `mem_ready`  in  1  memory has valid data on `mem_data` this cycle.
- `mem_data`  in  8  fetched instruction byte.
- `instruction`  out  8  latched instruction, to the ALU.
- `working_register`  out  wordsize  R0 (WR), to the ALU.
- `other_register`  out  wordsize  R[instruction[3:0]], to the ALU.
- `status_register`  out  wordsize  R1 (SR), to the ALU.
- `alu_out`  in  wordsize  ALU result.
- `alu_out_reg`  in  4  ALU destination register index.
- `halted`  out  1  core stopped by `slp`.

## Operation
- Register map (from `asrm.vh`): `wr_id`=0, `sr_id`=1, `pc_id`=2, R3..R15 general purpose.
- States: FETCH, EXEC, HALT.
- FETCH:
  - `mem_req`=1, `mem_addr`=PC.
  - On an edge with `mem_ready`=1: instruction register <= `mem_data`, go to EXEC.
  - Otherwise remain in FETCH, holding the request and address stable.
- EXEC (exactly one cycle):
  - `mem_req`=0; ALU inputs are driven from the latched instruction and the registers.
  - On the edge: R[`alu_out_reg`] <= `alu_out`.
  - If `alu_out_reg` != `pc_id`: PC <= PC+1, modulo 2^wordsize (0xFFFF wraps to 0x0000).
  - If `alu_out_reg` == `pc_id`: PC <= `alu_out`, with no increment (jump/taken jif/cpy to PC).
  - Next state is HALT if the instruction equals `inst_slp`, else FETCH.
- HALT:
  - `mem_req`=0, `halted`=1.
  - Only `reset` leaves HALT; `mem_ready` is ignored.
- `mem_ready` is ignored outside FETCH.
- Exactly one register is written per executed instruction. WR, SR and PC are ordinary entries and are writable by any instruction.
- `other_register` is an asynchronous read. When the index is 2, it returns the PC value before the EXEC update.

## Timing
- Reset values, asserted asynchronously:
  - R0..R15 = 0, except PC = `pc_reset`.
  - `instruction` = 0x00, state FETCH.
  - `mem_req` = 0 while `reset` is low, and 1 from the first cycle after release.
  - `halted` = 0.
- `mem_addr` tracks PC, so it equals `pc_reset` immediately.
- Throughput: minimum 2 cycles per instruction, when `mem_ready` is high in the request cycle. Each extra wait cycle adds 1.
- Cycle pattern:
  - n: FETCH with `mem_req`=1 and ready.
  - n+1: EXEC; writeback occurs on the closing edge.
  - n+2: FETCH at the new PC.
- Reset mid-fetch or mid-EXEC aborts with no register write; the first fetch after release is from `pc_reset`.

## Structure
- `asrm.vh`: `wr_id`, `sr_id`, `pc_id`, `inst_slp`, and the state encodings (2-bit localparam-style defines).
- Sub-module `asrm_regfile`:
  - 16 x wordsize registers.
  - One write port, plus a separate PC increment/load input.
  - Fixed WR/SR/PC read outputs and one indexed read.
- `asrm_fetch_regs` holds the state machine and instruction register, and instantiates `asrm_regfile`.

## Test plan
- Reset with `pc_reset`=0x0010 and `mem_ready` tied high: `mem_addr`=0x0010 and `mem_req`=0 during reset; `mem_req`=1 on the first post-reset cycle; `instruction` latches the next cycle.
- `set 5` with `mem_ready` delayed 3 cycles: `mem_req` and `mem_addr` are held for 3 cycles, then EXEC; WR=0x0005 and PC=0x0001 afterwards; total 5 cycles.
- `cpy 7` after `set 9`: R7=0x0009, WR unchanged, PC=2.
- `set 4`, `cpy 2` (to PC): next fetch address is 0x0004, not 0x0005.
- PC at 0xFFFF executing a non-jump: next `mem_addr`=0x0000.
- `slp`: after EXEC, `halted`=1 and `mem_req`=0 indefinitely despite `mem_ready` toggling; asserting `reset` low returns to FETCH at `pc_reset` with all registers cleared.

Source files
------------

// File: rtl/asrm_fetch_regs_pkg.sv
// asrm_fetch_regs_pkg
//   Shared register map, instruction and state encodings for the ASRM
//   fetch/register front end.
package asrm_fetch_regs_pkg;

   // Fixed register indices
   localparam logic [3:0] WR_ID = 4'd0;   // working register
   localparam logic [3:0] SR_ID = 4'd1;   // status register
   localparam logic [3:0] PC_ID = 4'd2;   // program counter

   // Instruction that stops the core after it executes
   localparam logic [7:0] INST_SLP = 8'hFF;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

endpackage

// File: rtl/asrm_regfile.sv
// asrm_regfile
//   16 x WORDSIZE register file for the ASRM core.
//   Ports:
//     clk, reset    : clock, asynchronous active-low reset
//     wr_en         : write wr_data into R[wr_idx]
//     wr_idx        : write index
//     wr_data       : write data
//     pc_inc        : increment PC by one (wraps modulo 2^WORDSIZE)
//     rd_idx        : indexed read address
//     rd_data       : asynchronous read of R[rd_idx]
//     wr, sr, pc    : fixed reads of R0, R1, R2
module asrm_regfile
   import asrm_fetch_regs_pkg::*;
#(
   parameter int                  WORDSIZE = 16,
   parameter logic [WORDSIZE-1:0] PC_RESET = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [3:0]          wr_idx,
   input  logic [WORDSIZE-1:0] wr_data,
   input  logic                pc_inc,
   input  logic [3:0]          rd_idx,
   output logic [WORDSIZE-1:0] rd_data,
   output logic [WORDSIZE-1:0] wr,
   output logic [WORDSIZE-1:0] sr,
   output logic [WORDSIZE-1:0] pc
);

   logic [15:0][WORDSIZE-1:0] regs;

   // The caller never raises pc_inc in the same cycle as a write to PC,
   // so the two PC updates below never collide.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs        <= '0;
         regs[PC_ID] <= PC_RESET;
      end else begin
         if (wr_en)  regs[wr_idx] <= wr_data;
         if (pc_inc) regs[PC_ID]  <= regs[PC_ID] + WORDSIZE'(1);
      end
   end

   assign rd_data = regs[rd_idx];
   assign wr      = regs[WR_ID];
   assign sr      = regs[SR_ID];
   assign pc      = regs[PC_ID];

endmodule

// File: rtl/asrm_fetch_regs.sv
// asrm_fetch_regs
//   Fetch/execute sequencer and register file wrapped around the
//   combinational ASRM ALU. Two phases: FETCH one byte over a req/ready
//   handshake, then EXEC for one cycle committing the ALU result.
//   Ports:
//     clk, reset         : clock, asynchronous active-low reset
//     mem_req/mem_addr   : fetch request, address (= PC)
//     mem_ready/mem_data : fetched byte valid / data
//     instruction        : latched instruction to the ALU
//     working_register   : R0 to the ALU
//     other_register     : R[instruction[3:0]] to the ALU
//     status_register    : R1 to the ALU
//     alu_out/alu_out_reg: ALU result and destination index
//     halted             : core stopped by slp
module asrm_fetch_regs
   import asrm_fetch_regs_pkg::*;
#(
   parameter int                  wordsize = 16,
   parameter logic [wordsize-1:0] pc_reset = '0
) (
   input  logic                clk,
   input  logic                reset,
   output logic                mem_req,
   output logic [wordsize-1:0] mem_addr,
   input  logic                mem_ready,
   input  logic [7:0]          mem_data,
   output logic [7:0]          instruction,
   output logic [wordsize-1:0] working_register,
   output logic [wordsize-1:0] other_register,
   output logic [wordsize-1:0] status_register,
   input  logic [wordsize-1:0] alu_out,
   input  logic [3:0]          alu_out_reg,
   output logic                halted
);

   state_t state, state_nxt;
   logic   exec;
   logic   pc_inc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_FETCH: if (mem_ready) state_nxt = ST_EXEC;
         ST_EXEC:  state_nxt = (instruction == INST_SLP) ? ST_HALT : ST_FETCH;
         ST_HALT:  state_nxt = ST_HALT;
         default:  state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                instruction <= 8'h00;
      else if (state == ST_FETCH && mem_ready)   instruction <= mem_data;
   end

   // State already sits in FETCH during reset; gating with reset keeps the
   // request low until release.
   assign mem_req = (state == ST_FETCH) && reset;
   assign halted  = (state == ST_HALT);
   assign exec    = (state == ST_EXEC);

   // A write aimed at PC is a jump: load instead of increment.
   assign pc_inc  = exec && (alu_out_reg != PC_ID);

   asrm_regfile #(
      .WORDSIZE (wordsize),
      .PC_RESET (pc_reset)
   ) u_rf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (exec),
      .wr_idx  (alu_out_reg),
      .wr_data (alu_out),
      .pc_inc  (pc_inc),
      .rd_idx  (instruction[3:0]),
      .rd_data (other_register),
      .wr      (working_register),
      .sr      (status_register),
      .pc      (mem_addr)
   );

endmodule

// File: tb/tb_asrm_fetch_regs.sv
// tb_asrm_fetch_regs
//   Bench for asrm_fetch_regs with a small behavioural ALU:
//     0x1n set n : WR <= n
//     0x2n cpy n : R[n] <= WR
//     0x3n ld  n : R[n] <= 0xFFFF
//     other      : WR <= WR (0xFF is slp)
//   Expected fetch addresses go into a queue as each instruction is
//   modelled and are popped when the DUT next requests a fetch.
module tb_asrm_fetch_regs;

   localparam logic [15:0] PCR = 16'h0010;
   localparam logic [7:0]  SLP = 8'hFF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic [7:0]  mem_data = 8'h00;
   logic [7:0]  instruction;
   logic [15:0] working_register, other_register, status_register;
   logic [15:0] alu_out;
   logic [3:0]  alu_out_reg;
   logic        halted;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [15:0] addr_q[$];
   logic [15:0] mr[16];

   asrm_fetch_regs #(.wordsize(16), .pc_reset(PCR)) dut (
      .clk              (clk),
      .reset            (reset),
      .mem_req          (mem_req),
      .mem_addr         (mem_addr),
      .mem_ready        (mem_ready),
      .mem_data         (mem_data),
      .instruction      (instruction),
      .working_register (working_register),
      .other_register   (other_register),
      .status_register  (status_register),
      .alu_out          (alu_out),
      .alu_out_reg      (alu_out_reg),
      .halted           (halted)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      alu_out     = working_register;
      alu_out_reg = 4'd0;
      case (instruction[7:4])
         4'h1: alu_out = {12'h000, instruction[3:0]};
         4'h2: alu_out_reg = instruction[3:0];
         4'h3: begin alu_out = 16'hFFFF; alu_out_reg = instruction[3:0]; end
         default: ;
      endcase
   end

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mr[i] = 16'h0000;
      mr[2] = PCR;
      addr_q.delete();
      addr_q.push_back(PCR);
   endtask

   // Fetch and execute one instruction, holding mem_ready low for wait_n cycles.
   task automatic exec_inst(input logic [7:0] inst, input int wait_n);
      int n, c0;
      logic [15:0] ea, v;
      logic [3:0]  d;
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (mem_req !== 1'b1) begin
         errors++; $display("FAIL fetch_timeout: mem_req=%b want 1", mem_req);
      end
      if (addr_q.size() == 0) begin
         errors++; $display("FAIL addr_queue: empty"); ea = 16'h0000;
      end else ea = addr_q.pop_front();
      c0 = cyc;
      checks++;
      if (mem_addr !== ea) begin
         errors++; $display("FAIL fetch_addr: got %h want %h", mem_addr, ea);
      end
      mem_ready = 1'b0;
      for (int i = 0; i < wait_n; i++) begin
         @(posedge clk); #1;
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== ea) begin
            errors++; $display("FAIL fetch_hold: req=%b addr=%h want 1 %h", mem_req, mem_addr, ea);
         end
      end
      mem_data  = inst;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      checks++;
      if (mem_req !== 1'b0 || instruction !== inst) begin
         errors++; $display("FAIL exec_latch: req=%b inst=%h want 0 %h", mem_req, instruction, inst);
      end
      checks++;
      if (working_register !== mr[0] || status_register !== mr[1] || other_register !== mr[inst[3:0]]) begin
         errors++;
         $display("FAIL exec_operands: wr=%h sr=%h other=%h want %h %h %h",
                  working_register, status_register, other_register, mr[0], mr[1], mr[inst[3:0]]);
      end
      d = 4'd0; v = mr[0];
      case (inst[7:4])
         4'h1: v = {12'h000, inst[3:0]};
         4'h2: d = inst[3:0];
         4'h3: begin d = inst[3:0]; v = 16'hFFFF; end
         default: ;
      endcase
      mr[d] = v;
      if (d != 4'd2) mr[2] = mr[2] + 16'd1;
      if (inst != SLP) addr_q.push_back(mr[2]);
      @(posedge clk); #1;
      checks++;
      if (halted !== (inst == SLP)) begin
         errors++; $display("FAIL halted_after_exec: got %b want %b", halted, inst == SLP);
      end
      if (inst != SLP) begin
         checks++;
         if (cyc - c0 != wait_n + 2) begin
            errors++; $display("FAIL cycle_count: got %0d want %0d", cyc - c0, wait_n + 2);
         end
      end
   endtask

   task automatic check_reset_state(input string nm);
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== PCR || halted !== 1'b0 || instruction !== 8'h00) begin
         errors++;
         $display("FAIL %s: req=%b addr=%h halted=%b inst=%h want 0 %h 0 00",
                  nm, mem_req, mem_addr, halted, instruction, PCR);
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b1) begin
         errors++; $display("FAIL first_req: got %b want 1", mem_req);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; mem_ready = 1'b1; mem_data = 8'h13;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_state("reset_state");
      release_reset();
      exec_inst(8'h13, 0);
   endtask

   task automatic test_wait();
      exec_inst(8'h15, 3);
      exec_inst(8'h00, 0);   // observes WR = 5
   endtask

   task automatic test_cpy();
      exec_inst(8'h19, 0);
      exec_inst(8'h27, 0);
      exec_inst(8'h07, 0);   // other_register shows R7
      exec_inst(8'h21, 0);   // copy into SR
      exec_inst(8'h00, 0);   // observe SR
   endtask

   task automatic test_jump();
      exec_inst(8'h14, 0);
      exec_inst(8'h22, 0);   // PC <= 4
      checks++;
      if (addr_q.size() == 0 || addr_q[0] !== 16'h0004) begin
         errors++; $display("FAIL jump_model: next addr not 0004");
      end
      exec_inst(8'h02, 0);   // other_register returns PC pre-update
   endtask

   task automatic test_wrap();
      exec_inst(8'h32, 0);   // PC <= FFFF
      exec_inst(8'h11, 0);   // fetched at FFFF, next at 0000
      exec_inst(8'h00, 0);
   endtask

   task automatic test_halt();
      exec_inst(SLP, 0);
      for (int i = 0; i < 8; i++) begin
         mem_ready = i[0];
         @(negedge clk);
         checks++;
         if (halted !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL halt_hold: halted=%b req=%b want 1 0", halted, mem_req);
         end
      end
      mem_ready = 1'b0;
      reset = 1'b0;
      #1;
      check_reset_state("halt_reset");
      model_reset();
      release_reset();
      exec_inst(8'h07, 0);   // all registers cleared
      exec_inst(8'h02, 0);
   endtask

   initial begin
      test_reset();
      test_wait();
      test_cpy();
      test_jump();
      test_wrap();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
